// File: rtl/mux_sel_pkg.sv
// Shared defaults and select-width helper for the registered N-to-1 mux.
package mux_sel_pkg;

  localparam int NUM_IN_DEF      = 31;
  localparam int WIDTH_DEF       = 2;
  localparam int DEFAULT_VAL_DEF = 1;

  // Select width: wide enough to encode NUM_IN itself, so that one
  // out-of-range code always exists. Never narrower than one bit.
  function automatic int sel_w_calc(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_sel_core.sv
// Combinational indexed select with range check. Each legal index decodes
// to exactly its own channel; any other code yields DEFAULT_VAL and err=1.
module mux_sel_core
  import mux_sel_pkg::*;
#(
  parameter int NUM_IN      = NUM_IN_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_VAL = DEFAULT_VAL_DEF,
  parameter int SEL_W       = sel_w_calc(NUM_IN)
) (
  input  logic [SEL_W-1:0]        ch,
  input  logic [NUM_IN*WIDTH-1:0] inp,
  output logic [WIDTH-1:0]        data,
  output logic                    err
);

  localparam logic [WIDTH-1:0] DEF_V = WIDTH'(DEFAULT_VAL);

  // One-hot compare against every legal index; no match means out of range.
  always_comb begin
    data = DEF_V;
    err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (ch == SEL_W'(i)) begin
        data = inp[i*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered, parametrised N-to-1 mux with a handshaked manual select,
// a round-robin auto-scan mode and an out-of-range error flag.
//
// Handshake rules (both sides are plain valid/ready):
//   - Manual request side: a select transfers on a rising edge where
//     sel_valid && sel_ready. sel_ready is combinational, depends only on
//     the output register being free and mode==0, never on sel_valid.
//   - Output side: out/out_ch/sel_err transfer on a rising edge where
//     out_valid && out_ready. While out_valid && !out_ready the output
//     register holds every field, whatever the inputs do.
module mux_sel_pipe
  import mux_sel_pkg::*;
#(
  parameter  int NUM_IN      = NUM_IN_DEF,
  parameter  int WIDTH       = WIDTH_DEF,
  parameter  int DEFAULT_VAL = DEFAULT_VAL_DEF,
  localparam int SEL_W       = sel_w_calc(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    sel_valid,
  input  logic [SEL_W-1:0]        sel,
  output logic                    sel_ready,
  input  logic [NUM_IN*WIDTH-1:0] inp,
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

  logic             load;
  logic             req;
  logic [SEL_W-1:0] ch;
  logic [SEL_W-1:0] scan_ptr;
  logic [WIDTH-1:0] core_data;
  logic             core_err;

  // Handshake decode: output register free, request present, chosen index.
  always_comb begin
    load      = !out_valid || out_ready;
    req       = mode ? 1'b1 : sel_valid;
    ch        = mode ? scan_ptr : sel;
    sel_ready = load && !mode;
  end

  mux_sel_core #(
    .NUM_IN      (NUM_IN),
    .WIDTH       (WIDTH),
    .DEFAULT_VAL (DEFAULT_VAL),
    .SEL_W       (SEL_W)
  ) u_core (
    .ch   (ch),
    .inp  (inp),
    .data (core_data),
    .err  (core_err)
  );

  // Scan pointer: parked at 0 in manual mode so each scan starts at channel 0,
  // advances on every load in scan mode and wraps after the last channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr <= '0;
    end else if (!mode) begin
      scan_ptr <= '0;
    end else if (load) begin
      scan_ptr <= (scan_ptr == LAST_CH) ? '0 : scan_ptr + 1'b1;
    end
  end

  // Output register: capture on load with a request, drop valid on load
  // without one, hold everything while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (load) begin
      if (req) begin
        out       <= core_data;
        out_ch    <= ch;
        sel_err   <= core_err;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe at default parameters. Stimulus pushes the
// expected {sel_err, out_ch, out} into a queue; a negedge monitor pops and
// compares on every output transfer.
module tb_mux_sel_pipe;

  localparam int NUM_IN = 31;
  localparam int WIDTH  = 2;
  localparam int SEL_W  = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    mode = 1'b0;
  logic                    sel_valid = 1'b0;
  logic [SEL_W-1:0]        sel = '0;
  logic                    sel_ready;
  logic [NUM_IN*WIDTH-1:0] inp;
  logic [WIDTH-1:0]        out;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    sel_err;

  logic [NUM_IN*WIDTH-1:0] base_inp;
  logic [7:0]              exp_q[$];
  int                      total = 0;
  int                      bad = 0;

  mux_sel_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .inp       (inp),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Channel contents: i mod 4, except 12 -> 2'b10 and 13 -> 2'b01.
  function automatic logic [1:0] chan_val(input int i);
    if (i == 12) return 2'b10;
    if (i == 13) return 2'b01;
    return 2'(i % 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected entry for a given select: in range -> channel data, else default.
  function automatic logic [7:0] exp_for(input int s);
    if (s < NUM_IN) return {1'b0, 5'(s), chan_val(s)};
    return {1'b1, 5'(s), 2'b01};
  endfunction

  // Driver: issue a manual select and push its expectation on acceptance.
  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input int s);
    bit done;
    done = 0;
    mode = 1'b0;
    sel_valid = 1'b1;
    sel = 5'(s);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (sel_ready) begin
        exp_q.push_back(exp_for(s));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: sel=%0d not accepted, want accept within 20 cycles", s);
    end
  endtask

  // Monitor: compare every output transfer against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got ch=%0d out=%0h err=%0b, want no output", out_ch, out, sel_err);
      end else begin
        check("out_xfer", {24'd0, sel_err, out_ch, out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    for (int i = 0; i < NUM_IN; i++) base_inp[i*WIDTH +: WIDTH] = chan_val(i);
    inp = base_inp;

    // Reset state
    @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out", 32'(out), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. Manual sweep of every legal channel
    for (int s = 0; s < NUM_IN; s++) send(s);

    // 2. Out-of-range select, then back in range
    send(31);
    send(5);

    // 3. Backpressure: hold sel=7 output while inputs churn
    send(7);
    out_ready = 1'b0;
    sel = 5'd9;
    sel_valid = 1'b1;
    inp = ~base_inp;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out", 32'(out), 3);
      check("bp_out_ch", 32'(out_ch), 7);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_sel_ready", 32'(sel_ready), 0);
      @(posedge clk);
      #1;
    end
    inp = base_inp;
    out_ready = 1'b1;
    send(9);

    // 5. Idle: valid drops, data holds
    send(6);
    sel_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_out", 32'(out), 2);
    check("idle_out_ch", 32'(out_ch), 6);
    @(posedge clk);
    #1;

    // 4. Scan wrap, continuing until out_ch=17 on the second lap
    for (int k = 0; k < 49; k++) begin
      mode = 1'b1;
      #0;
      check("scan_sel_ready", 32'(sel_ready), 0);
      exp_q.push_back(exp_for(k % NUM_IN));
      @(posedge clk);
      #1;
    end
    check("scan_pre_rst_ch", 32'(out_ch), 17);

    // 6. Async reset between edges mid-scan
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out", 32'(out), 0);
    check("arst_out_ch", 32'(out_ch), 0);
    check("arst_sel_err", 32'(sel_err), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(exp_for(0));
    @(posedge clk);
    #1;
    exp_q.push_back(exp_for(1));
    @(posedge clk);
    #1;
    mode = 1'b0;
    sel_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
Registered, parametrised N-to-1 multiplexer. Successor to the fixed 31-input, 2-bit combinational mux.
- Adds a handshake-qualified select with 1-cycle latency and output backpressure.
- Adds an auto-scan mode that round-robins through all channels.
- Adds an out-of-range select error flag.
Sits between a bank of sampled sources and a single downstream consumer.

Parameters:
NUM_IN, 31, number of input channels (2..256).
WIDTH, 2, bits per channel.
DEFAULT_VAL, 1, value driven on out for an out-of-range select (truncated to WIDTH).
SEL_W, derived localparam = max(1, $clog2(NUM_IN+1)), select width. With the defaults SEL_W=5, so sel=31 is representable and out of range.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
mode  in  1  0 = manual select, 1 = auto-scan.
sel_valid  in  1  manual select request (ignored when mode=1).
sel  in  SEL_W  manual channel index.
sel_ready  out  1  combinational: manual request accepted this cycle.
inp  in  NUM_IN*WIDTH  flattened inputs; channel i = inp[i*WIDTH +: WIDTH].
out  out  WIDTH  registered selected data.
out_ch  out  SEL_W  channel index that produced out.
out_valid  out  1  out/out_ch/sel_err valid.
out_ready  in  1  consumer accepts output.
sel_err  out  1  the current output came from an out-of-range select.

Behaviour:
- Reset (asynchronous, rst=1): out=0, out_ch=0, out_valid=0, sel_err=0, scan_ptr=0.
- load = !out_valid || out_ready. The output register can take new data this cycle.
- req = (mode==0) ? sel_valid : 1.
- ch = (mode==0) ? sel : scan_ptr.
- sel_ready = load && (mode==0). This is combinational and must not depend on sel_valid.
- On a clock edge with load && req:
  - out <= (ch < NUM_IN) ? channel[ch] : DEFAULT_VAL.
  - out_ch <= ch.
  - sel_err <= (ch >= NUM_IN).
  - out_valid <= 1.
- On a clock edge with load && !req: out_valid <= 0. out, out_ch and sel_err hold.
- On a clock edge with !load (out_valid && !out_ready): all outputs hold. Input changes are not reflected.
- Latency: data is sampled on the accept edge and appears on out in the next cycle. Throughput is 1 per cycle when out_ready is held at 1.
- Scan:
  - scan_ptr advances only when mode==1 && load.
  - scan_ptr wraps from NUM_IN-1 to 0.
  - scan_ptr is cleared to 0 on any cycle with mode==0, so every scan entry starts at channel 0.
  - scan never produces sel_err.
- Mode change while out_valid && !out_ready: the held output is preserved. The new mode takes effect at the next load.
- Every index 0..NUM_IN-1 maps to exactly its own channel. Duplicate or missing decode entries are a bug.
- Out-of-range selects are still delivered, with DEFAULT_VAL and sel_err=1. They are not dropped.
- Reset mid-transfer: outputs clear immediately, with no clock edge needed. The first post-reset accept behaves as from cold.

Decomposition:
- Package mux_sel_pkg holds the default constants (NUM_IN_DEF=31, WIDTH_DEF=2, DEFAULT_VAL_DEF=1) and the SEL_W computation function.
- One natural sub-module: mux_sel_core. It is the purely combinational indexed select with range check, taking ch and inp and returning data and err.
- The top module holds the handshake, scan pointer and output register.

Test Plan:
(All cases use defaults; inp set so channel i = i mod 4, except channel 12 = 2'b10 and channel 13 = 2'b01.)
1. Manual sweep: mode=0, sel_valid=1, out_ready=1, sel=0..30, one per cycle.
   -> each next cycle out=channel[sel], out_ch=sel, sel_err=0.
   -> explicitly sel=12 gives out=2'b10, sel=13 gives 2'b01, and sel=30 gives out=2'b10 (30 mod 4 = 2) with out_ch=30.
2. Out of range: sel=31.
   -> out=2'b01, out_ch=31, sel_err=1, out_valid=1.
   -> then sel=5 clears sel_err to 0 with out=2'b01.
3. Backpressure: sel=7 accepted, then out_ready=0 for 3 cycles while sel=9 and inp changes.
   -> out=2'b11 and out_ch=7 hold; sel_ready=0.
   -> on out_ready=1, sel=9 is accepted and out=2'b01 the next cycle.
4. Scan wrap: mode=1, out_ready=1 for 33 cycles.
   -> out_ch sequence 0,1,...,30,0,1. sel_err always 0. sel_ready=0 throughout.
5. Idle: mode=0, sel_valid=0 after one transfer.
   -> out_valid drops to 0 the next cycle; out and out_ch hold their last values.
6. Async reset mid-scan: assert rst between clock edges at out_ch=17.
   -> out_valid, out, out_ch and sel_err go to 0 immediately.
   -> after release with mode=1, the first output is out_ch=0.
